// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO and back-to-back framing.
// Optional line-break control is enabled by defining UART_TX_FIFO_BREAK_EN.
module uart_tx_fifo #(
  parameter int DATA_W     = 9,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ce,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [3:0]            i_length,
  input  logic                  i_stop2,
  input  logic                  i_parity,
  input  logic                  i_odd,
`ifdef UART_TX_FIFO_BREAK_EN
  input  logic                  i_break,
`endif
  output logic                  o_tx,
  output logic                  o_busy,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_empty,
  output logic                  o_full
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [4:0] MAX_CNT = 5'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP2  = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  state_t                state;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DATA_W-1:0]     shreg;
  logic [DATA_W-1:0]     head;
  logic [DATA_W-1:0]     act_mask;
  logic [4:0]            bit_cnt;
  logic [4:0]            cnt_load;
  logic                  stop2_q;
  logic                  parity_q;
  logic                  pbit_q;
  logic                  tx_q;
  logic                  brk;
  logic                  wr_en;
  logic                  pop;

`ifdef UART_TX_FIFO_BREAK_EN
  assign brk  = i_break;
  assign o_tx = tx_q & ~(i_break && state == S_IDLE);
`else
  assign brk  = 1'b0;
  assign o_tx = tx_q;
`endif

  // Write handshake: a word is accepted on any i_clk edge where i_valid && o_ready;
  // o_ready is simply !o_full, and a write offered while full is dropped.
  assign o_empty = (count == '0);
  assign o_full  = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign o_ready = !o_full;
  assign o_level = count;
  assign o_busy  = (state != S_IDLE) || !o_empty;
  assign head    = mem[rd_ptr];
  assign wr_en   = i_valid && !o_full;
  assign pop     = i_ce && !o_empty && !brk && (state == S_IDLE || state == S_STOP);

  // Bit counter holds N-1; lengths beyond the word width clamp to DATA_W bits.
  assign cnt_load = ({1'b0, i_length} > MAX_CNT) ? MAX_CNT : {1'b0, i_length};

  always_comb begin
    act_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      act_mask[i] = (5'(i) <= cnt_load);
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (pop && !wr_en) count <= count - 1'b1;
    end
  end

  // o_tx is registered on the i_ce edge that enters each state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      tx_q     <= 1'b1;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop2_q  <= 1'b0;
      parity_q <= 1'b0;
      pbit_q   <= 1'b0;
    end else if (i_ce) begin
      case (state)
        S_IDLE, S_STOP: begin
          if (pop) begin
            state    <= S_START;
            tx_q     <= 1'b0;
            shreg    <= head;
            bit_cnt  <= cnt_load;
            stop2_q  <= i_stop2;
            parity_q <= i_parity;
            pbit_q   <= (^(head & act_mask)) ^ i_odd;
          end else begin
            state <= S_IDLE;
            tx_q  <= 1'b1;
          end
        end
        S_START: begin
          state <= S_DATA;
          tx_q  <= shreg[0];
          shreg <= {1'b1, shreg[DATA_W-1:1]};
        end
        S_DATA: begin
          if (bit_cnt != 5'd0) begin
            tx_q    <= shreg[0];
            shreg   <= {1'b1, shreg[DATA_W-1:1]};
            bit_cnt <= bit_cnt - 5'd1;
          end else if (parity_q) begin
            state <= S_PARITY;
            tx_q  <= pbit_q;
          end else begin
            state <= stop2_q ? S_STOP2 : S_STOP;
            tx_q  <= 1'b1;
          end
        end
        S_PARITY: begin
          state <= stop2_q ? S_STOP2 : S_STOP;
          tx_q  <= 1'b1;
        end
        S_STOP2: begin
          state <= S_STOP;
          tx_q  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a serial monitor decodes frames and checks
// them against hand-computed frames queued by the stimulus.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int DATA_W     = 9;
  localparam int DEPTH_LOG2 = 2;

  // bits[0] is the first bit on the line (start bit), len is bits per frame.
  typedef struct packed {
    logic [15:0] bits;
    logic [4:0]  len;
    logic        b2b;
  } frame_t;

  logic                i_clk = 1'b0;
  logic                i_rst;
  logic                i_ce;
  logic [DATA_W-1:0]   i_data;
  logic                i_valid;
  logic [3:0]          i_length;
  logic                i_stop2;
  logic                i_parity;
  logic                i_odd;
  logic                o_ready;
  logic                o_tx;
  logic                o_busy;
  logic [DEPTH_LOG2:0] o_level;
  logic                o_empty;
  logic                o_full;
`ifdef UART_TX_FIFO_BREAK_EN
  logic                i_break;
`endif

  frame_t exp_q[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  int     ce_div   = 4;
  bit     ce_off   = 1'b1;
  bit     ce_manual = 1'b0;
  logic   ce_force = 1'b0;
  logic   ce_auto  = 1'b0;
  bit     mon_en   = 1'b1;
  bit     rx_busy  = 1'b0;

  uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_ce     (i_ce),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_length (i_length),
    .i_stop2  (i_stop2),
    .i_parity (i_parity),
    .i_odd    (i_odd),
`ifdef UART_TX_FIFO_BREAK_EN
    .i_break  (i_break),
`endif
    .o_tx     (o_tx),
    .o_busy   (o_busy),
    .o_level  (o_level),
    .o_empty  (o_empty),
    .o_full   (o_full)
  );

  // Clock and bit-enable generation
  always #5 i_clk = ~i_clk;

  assign i_ce = ce_manual ? ce_force : ce_auto;

  initial begin : ce_gen
    int cnt;
    cnt = 0;
    forever begin
      @(negedge i_clk);
      if (ce_off) begin
        ce_auto = 1'b0;
      end else begin
        ce_auto = (cnt == 0);
        cnt = (cnt + 1 >= ce_div) ? 0 : cnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Driver tasks
  task automatic write_word(input logic [DATA_W-1:0] d);
    i_data  = d;
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic push_frame(input logic [15:0] bits, input int len, input bit b2b);
    frame_t f;
    f.bits = bits;
    f.len  = 5'(len);
    f.b2b  = b2b;
    exp_q.push_back(f);
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int k;
    k = 0;
    while (o_busy && k < max_cyc) begin
      @(negedge i_clk);
      k++;
    end
    check(name, o_busy, 1'b0);
  endtask

  // Monitor: one line bit per i_ce period, sampled just after the i_ce edge.
  initial begin : monitor
    frame_t      cur;
    logic [15:0] got;
    int          nbit;
    int          ce_idx;
    int          last_end;
    logic        ce_s;
    logic        rst_s;
    cur = '0;
    got = '0;
    nbit = 0;
    ce_idx = 0;
    last_end = -100;
    forever begin
      @(posedge i_clk);
      ce_s  = i_ce;
      rst_s = i_rst;
      #1;
      if (rst_s) begin
        rx_busy = 1'b0;
      end else if (ce_s && mon_en) begin
        ce_idx++;
        if (!rx_busy) begin
          if (o_tx === 1'b0) begin
            check("frame_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
              cur = exp_q.pop_front();
              got = '0;
              nbit = 1;
              rx_busy = 1'b1;
              if (cur.b2b) check("b2b_no_gap", ce_idx, last_end + 1);
            end
          end
        end else begin
          got[nbit] = o_tx;
          nbit++;
          if (nbit == int'(cur.len)) begin
            check("frame_bits", 32'(got), 32'(cur.bits));
            rx_busy = 1'b0;
            last_end = ce_idx;
          end
        end
      end
    end
  end

  // Stimulus
  initial begin : stim
    int k;
    int bad;
    i_rst = 1'b1; i_valid = 1'b0; i_data = '0;
    i_length = 4'd7; i_stop2 = 1'b0; i_parity = 1'b0; i_odd = 1'b0;
`ifdef UART_TX_FIFO_BREAK_EN
    i_break = 1'b0;
`endif
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_tx", o_tx, 1);
    check("rst_busy", o_busy, 0);
    check("rst_level", o_level, 0);
    check("rst_empty", o_empty, 1);
    check("rst_full", o_full, 0);
    check("rst_ready", o_ready, 1);

    // Basic 8N1 frame of 0x55 with one bit every 4 clocks
    ce_div = 4; ce_off = 1'b0;
    push_frame(16'h02AA, 10, 1'b0);
    write_word(9'h055);
    check("basic_level", o_level, 1);
    check("basic_busy", o_busy, 1);
    wait_idle("basic_idle", 200);
    check("basic_level_end", o_level, 0);
    check("basic_tx_end", o_tx, 1);

    // 5 data bits, odd parity, 2 stops; config change after the pop is ignored
    ce_div = 0; i_length = 4'd4; i_parity = 1'b1; i_odd = 1'b1; i_stop2 = 1'b1;
    push_frame(16'h018E, 9, 1'b0);
    write_word(9'h1E7);
    repeat (3) @(negedge i_clk);
    i_odd = 1'b0;
    wait_idle("odd_idle", 100);
    push_frame(16'h01CE, 9, 1'b0);
    write_word(9'h1E7);
    wait_idle("even_idle", 100);

    // Length 15 clamps to all 9 bits
    i_length = 4'd15; i_parity = 1'b0; i_stop2 = 1'b0;
    push_frame(16'h07CE, 11, 1'b0);
    write_word(9'h1E7);
    wait_idle("clamp_idle", 100);

    // Fill the FIFO, drop a fifth write, then drain back-to-back
    i_length = 4'd7; ce_off = 1'b1;
    @(negedge i_clk);
    push_frame(16'h0202, 10, 1'b0);
    push_frame(16'h0300, 10, 1'b1);
    push_frame(16'h034A, 10, 1'b1);
    push_frame(16'h0278, 10, 1'b1);
    write_word(9'h001);
    write_word(9'h080);
    write_word(9'h0A5);
    write_word(9'h03C);
    check("full_level", o_level, 4);
    check("full_flag", o_full, 1);
    check("full_ready", o_ready, 0);
    write_word(9'h0FF);
    check("drop_level", o_level, 4);
    ce_div = 3; ce_off = 1'b0;
    wait_idle("b2b_idle", 400);
    check("b2b_level_end", o_level, 0);

    // Write and pop on the same edge
    ce_off = 1'b1;
    @(negedge i_clk);
    push_frame(16'h0222, 10, 1'b0);
    push_frame(16'h0244, 10, 1'b1);
    push_frame(16'h0266, 10, 1'b1);
    write_word(9'h011);
    write_word(9'h022);
    check("simul_level_pre", o_level, 2);
    ce_force = 1'b1; ce_manual = 1'b1; i_data = 9'h033; i_valid = 1'b1;
    @(negedge i_clk);
    ce_manual = 1'b0; ce_force = 1'b0; i_valid = 1'b0;
    check("simul_level_post", o_level, 2);
    ce_div = 2; ce_off = 1'b0;
    wait_idle("simul_idle", 400);

    // Reset during DATA bit 3 with three words still queued
    ce_off = 1'b1;
    @(negedge i_clk);
    push_frame(16'h021E, 10, 1'b0);
    write_word(9'h00F);
    write_word(9'h0F0);
    write_word(9'h033);
    write_word(9'h0CC);
    ce_div = 4; ce_off = 1'b0;
    k = 0;
    while (o_level != 3'd3 && k < 20) begin
      @(negedge i_clk);
      k++;
    end
    check("rst_mid_popped", o_level, 3);
    repeat (17) @(negedge i_clk);
    i_rst = 1'b1;
    exp_q.delete();
    @(negedge i_clk);
    i_rst = 1'b0;
    check("rst_mid_tx", o_tx, 1);
    check("rst_mid_level", o_level, 0);
    check("rst_mid_busy", o_busy, 0);
    check("rst_mid_empty", o_empty, 1);
    repeat (100) @(negedge i_clk);
    check("rst_mid_quiet", o_busy, 0);

`ifdef UART_TX_FIFO_BREAK_EN
    // Break holds the line low and blocks the pop until released
    ce_div = 2; mon_en = 1'b0; i_break = 1'b1;
    @(negedge i_clk);
    write_word(9'h05A);
    bad = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_tx !== 1'b0) bad++;
    end
    check("break_tx_high_cycles", bad, 0);
    check("break_level", o_level, 1);
    push_frame(16'h02B4, 10, 1'b0);
    i_break = 1'b0; mon_en = 1'b1;
    k = 0;
    while (o_tx !== 1'b0 && k < 10) begin
      @(negedge i_clk);
      k++;
    end
    check("break_resume", 32'(k <= 2 && o_tx === 1'b0), 1);
    wait_idle("break_idle", 200);
`else
    bad = 0;
`endif

    k = 0;
    while ((exp_q.size() != 0 || rx_busy) && k < 500) begin
      @(negedge i_clk);
      k++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    check("monitor_idle", 32'(rx_busy), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
